// File: rtl/reg_trace_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_trace_uart_tx_pkg
// Description : Shared constants, entry type and FSM encodings for the
//               register-writeback trace UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_trace_uart_tx_pkg;

    localparam logic [7:0] UART_TRACE_SYNC   = 8'hA5;
    localparam int         TRACE_FRAME_BYTES = 6;

    // Index value meaning "every byte of the frame has been handed off"
    localparam logic [2:0] FRAME_DONE_IDX = 3'(TRACE_FRAME_BYTES);

    typedef struct packed {
        logic [4:0]  id;
        logic [31:0] data;
    } trace_entry_t;

    localparam logic [0:0] FRM_IDLE = 1'b0;
    localparam logic [0:0] FRM_SEND = 1'b1;

    localparam logic [1:0] SER_READY = 2'd0;
    localparam logic [1:0] SER_START = 2'd1;
    localparam logic [1:0] SER_DATA  = 2'd2;
    localparam logic [1:0] SER_STOP  = 2'd3;

    function automatic logic [7:0] trace_byte(input trace_entry_t e, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = UART_TRACE_SYNC;
            3'd1:    b = {3'b000, e.id};
            3'd2:    b = e.data[7:0];
            3'd3:    b = e.data[15:8];
            3'd4:    b = e.data[23:16];
            3'd5:    b = e.data[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_trace_uart_tx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_byte
// Description : 8N1 byte serializer; accepts a new byte in its last stop-bit
//               cycle so consecutive bytes leave with no idle gap.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_byte
    import reg_trace_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx_serial
);

    localparam int                CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SER_READY;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        case (state_q)
            SER_READY: begin
                if (valid) begin
                    state_d = SER_START;
                    shift_d = data;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                end
            end
            SER_START: begin
                if (bit_end) begin
                    state_d = SER_DATA;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SER_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = SER_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            SER_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when a byte is waiting
                    if (valid) begin
                        state_d = SER_START;
                        shift_d = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = SER_READY;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = SER_READY;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_comb begin
        ready     = (state_q == SER_READY) || ((state_q == SER_STOP) && bit_end);
        tx_serial = tx_q;
    end

endmodule
`default_nettype wire

// File: rtl/reg_trace_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : reg_trace_uart_tx
// Description : Queues WB-stage register writes and streams each one to the
//               host as a 6-byte UART frame (sync, id, data LSB..MSB).
// Revision    : 1.0 - initial release
// ============================================================================
module reg_trace_uart_tx
    import reg_trace_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        reg_write,
    input  logic [4:0]  write_id,
    input  logic [31:0] write_data,
    output logic        tx_serial,
    output logic        busy,
    output logic        overflow
);

    localparam int               CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int               ADDR_W       = $clog2(FIFO_DEPTH);
    localparam int               PTR_W        = ADDR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE      = PTR_W'(1);

    trace_entry_t     fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;
    logic [0:0]       frm_state_q, frm_state_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    trace_entry_t     frame_q, frame_d;

    logic             fifo_empty, fifo_full;
    logic             push_req, push_ok, pop;
    logic             ser_valid, ser_ready, last_done;
    logic [7:0]       ser_data;
    trace_entry_t     head_entry, new_entry;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign head_entry = fifo_mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign new_entry  = '{id: write_id, data: write_data};
    assign push_req   = start && reg_write && (write_id != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            frm_state_q <= FRM_IDLE;
            byte_idx_q  <= 3'd0;
            frame_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            frm_state_q <= frm_state_d;
            byte_idx_q  <= byte_idx_d;
            frame_q     <= frame_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem_q[wr_ptr_q[ADDR_W-1:0]] <= new_entry;
        end
    end

    always_comb begin
        push_ok    = push_req && (!fifo_full || pop);
        wr_ptr_d   = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d   = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        overflow_d = overflow_q || (push_req && fifo_full && !pop);

        frm_state_d = frm_state_q;
        byte_idx_d  = byte_idx_q;
        frame_d     = frame_q;
        case (frm_state_q)
            FRM_IDLE: begin
                if (pop) begin
                    frm_state_d = FRM_SEND;
                    byte_idx_d  = 3'd0;
                    frame_d     = head_entry;
                end
            end
            FRM_SEND: begin
                if (ser_valid && ser_ready) begin
                    byte_idx_d = byte_idx_q + 3'd1;
                end else if (last_done) begin
                    if (pop) begin
                        byte_idx_d = 3'd0;
                        frame_d    = head_entry;
                    end else begin
                        frm_state_d = FRM_IDLE;
                    end
                end
            end
            default: frm_state_d = FRM_IDLE;
        endcase
    end

    // Reloading during the final stop-bit cycle leaves one idle cycle between frames
    always_comb begin
        ser_valid = (frm_state_q == FRM_SEND) && (byte_idx_q != FRAME_DONE_IDX);
        ser_data  = trace_byte(frame_q, byte_idx_q);
        last_done = (frm_state_q == FRM_SEND) && (byte_idx_q == FRAME_DONE_IDX) && ser_ready;
        pop       = !fifo_empty && ((frm_state_q == FRM_IDLE) || last_done);
        busy      = !fifo_empty || (frm_state_q != FRM_IDLE);
        overflow  = overflow_q;
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx_byte (
        .clk       (clk),
        .rst       (rst),
        .data      (ser_data),
        .valid     (ser_valid),
        .ready     (ser_ready),
        .tx_serial (tx_serial)
    );

endmodule
`default_nettype wire

// File: tb/tb_reg_trace_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_trace_uart_tx
// Description : Directed bench for reg_trace_uart_tx with a cycle-level
//               reference model, a line decoder and literal checkpoints.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_trace_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 16;
    localparam int FLEN  = 60 * CPB;

    logic        clk = 1'b0;
    logic        rst, start, reg_write;
    logic [4:0]  write_id;
    logic [31:0] write_data;
    logic        tx_serial, busy, overflow;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;
    int last_ev;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_trace_uart_tx #(
        .CLK_FREQ   (16),
        .BAUD_RATE  (1),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .reg_write  (reg_write),
        .write_id   (write_id),
        .write_data (write_data),
        .tx_serial  (tx_serial),
        .busy       (busy),
        .overflow   (overflow)
    );

    // Reference model: queue of events, line either idle, in a 1-cycle gap, or mid-frame
    logic [36:0] m_q[$];
    logic [59:0] m_bits;
    int          m_mode = 0;
    int          m_pos  = 0;
    bit          m_ovf  = 1'b0;
    bit          m_pop, m_push;

    function automatic logic [59:0] frame_bits(input logic [36:0] e);
        logic [7:0]  b [6];
        logic [59:0] f;
        b[0] = 8'hA5;
        b[1] = {3'b000, e[36:32]};
        b[2] = e[7:0];
        b[3] = e[15:8];
        b[4] = e[23:16];
        b[5] = e[31:24];
        f = '0;
        for (int k = 0; k < 6; k++) begin
            f[10*k] = 1'b0;
            for (int i = 0; i < 8; i++) f[10*k+1+i] = b[k][i];
            f[10*k+9] = 1'b1;
        end
        return f;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_mode = 0;
            m_pos  = 0;
            m_ovf  = 1'b0;
        end else begin
            m_pop = 1'b0;
            if (m_mode == 0) begin
                if (m_q.size() > 0) m_pop = 1'b1;
            end else if (m_mode == 1) begin
                m_mode = 2;
                m_pos  = 0;
            end else begin
                m_pos++;
                if (m_pos == FLEN) begin
                    if (m_q.size() > 0) m_pop = 1'b1;
                    else m_mode = 0;
                end
            end
            m_push = start && reg_write && (write_id != 5'd0);
            if (m_pop) begin
                m_bits = frame_bits(m_q.pop_front());
                m_mode = 1;
            end
            if (m_push) begin
                if (m_q.size() < DEPTH) m_q.push_back({write_id, write_data});
                else m_ovf = 1'b1;
            end
        end
    end

    logic exp_tx, exp_busy;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_tx   = (m_mode == 2) ? m_bits[m_pos / CPB] : 1'b1;
            exp_busy = (m_q.size() != 0) || (m_mode != 0);
            n_vec++;
            if (tx_serial !== exp_tx || busy !== exp_busy || overflow !== m_ovf) begin
                n_miss++;
                if (n_miss <= 20)
                    $display("FAIL model cyc=%0d tx/busy/ovf got %b%b%b want %b%b%b",
                             cyc, tx_serial, busy, overflow, exp_tx, exp_busy, m_ovf);
            end
        end
    end

    // Independent line decoder: samples mid-bit, records each byte and its start cycle
    logic [7:0] rx_bytes[$];
    int         rx_t0[$];
    bit         d_act = 1'b0;
    int         d_t0, d_k;
    logic [7:0] d_byte;

    always @(negedge clk) begin
        if (rst) begin
            d_act = 1'b0;
        end else if (!d_act) begin
            if (tx_serial === 1'b0) begin
                d_act = 1'b1;
                d_t0  = cyc;
            end
        end else begin
            d_k = cyc - d_t0;
            if ((d_k % CPB) == CPB/2 && (d_k / CPB) >= 1 && (d_k / CPB) <= 8)
                d_byte[d_k/CPB - 1] = tx_serial;
            if (d_k == 9*CPB + CPB/2) begin
                rx_bytes.push_back(d_byte);
                rx_t0.push_back(d_t0);
                d_act = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic ev(input logic [4:0] id, input logic [31:0] d, input logic st);
        start      = st;
        reg_write  = 1'b1;
        write_id   = id;
        write_data = d;
        last_ev    = cyc + 1;
        @(negedge clk);
        reg_write  = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'b0, busy}, 32'd0);
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        rx_bytes.delete();
        rx_t0.delete();
    endtask

    task automatic chk_frame(input int f, input logic [4:0] id, input logic [31:0] d, input string name);
        chk({name, "_sync"}, {24'b0, rx_bytes[6*f]},   32'hA5);
        chk({name, "_id"},   {24'b0, rx_bytes[6*f+1]}, {27'b0, id});
        chk({name, "_data"}, {rx_bytes[6*f+5], rx_bytes[6*f+4], rx_bytes[6*f+3], rx_bytes[6*f+2]}, d);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    int e0;
    initial begin
        rst = 1'b1; start = 1'b0; reg_write = 1'b0; write_id = 5'd0; write_data = 32'd0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_tx",   {31'b0, tx_serial}, 32'd1);
        chk("reset_busy", {31'b0, busy},      32'd0);
        chk("reset_ovf",  {31'b0, overflow},  32'd0);
        do_reset();

        // Single event: start bit two edges after capture, 960-cycle frame
        ev(5'd5, 32'h1234_5678, 1'b1);
        e0 = last_ev;
        wait_cyc(e0 + 1);   chk("single_pre_start", {31'b0, tx_serial}, 32'd1);
        wait_cyc(e0 + 2);   chk("single_start_bit", {31'b0, tx_serial}, 32'd0);
        wait_cyc(e0 + 961); chk("single_busy_end",  {31'b0, busy},      32'd1);
        wait_cyc(e0 + 962); chk("single_busy_drop", {31'b0, busy},      32'd0);
        repeat (5) @(negedge clk);
        chk("single_nbytes", rx_bytes.size(), 32'd6);
        if (rx_bytes.size() >= 6) begin
            chk("single_b0", {24'b0, rx_bytes[0]}, 32'hA5);
            chk("single_b1", {24'b0, rx_bytes[1]}, 32'h05);
            chk("single_b2", {24'b0, rx_bytes[2]}, 32'h78);
            chk("single_b3", {24'b0, rx_bytes[3]}, 32'h56);
            chk("single_b4", {24'b0, rx_bytes[4]}, 32'h34);
            chk("single_b5", {24'b0, rx_bytes[5]}, 32'h12);
        end
        rx_bytes.delete(); rx_t0.delete();

        // x0 writes and start=0 are ignored
        ev(5'd0, 32'hFFFF_FFFF, 1'b1);
        ev(5'd3, 32'h0000_0003, 1'b0);
        repeat (50) @(negedge clk);
        chk("filter_nbytes", rx_bytes.size(), 32'd0);
        chk("filter_busy", {31'b0, busy}, 32'd0);

        // Burst of three back-to-back events
        ev(5'd1, 32'hA000_0001, 1'b1);
        ev(5'd2, 32'hB000_0002, 1'b1);
        ev(5'd3, 32'hC000_0003, 1'b1);
        wait_idle(4000, "burst_drain");
        chk("burst_nbytes", rx_bytes.size(), 32'd18);
        if (rx_bytes.size() >= 18) begin
            chk_frame(0, 5'd1, 32'hA000_0001, "burst_f0");
            chk_frame(1, 5'd2, 32'hB000_0002, "burst_f1");
            chk_frame(2, 5'd3, 32'hC000_0003, "burst_f2");
            chk("burst_gap01", 32'(rx_t0[6] - rx_t0[0]),  32'd961);
            chk("burst_gap12", 32'(rx_t0[12] - rx_t0[6]), 32'd961);
        end
        rx_bytes.delete(); rx_t0.delete();

        // Overflow: 18 consecutive events, the last one is dropped
        chk("ovf_pre", {31'b0, overflow}, 32'd0);
        for (int i = 1; i <= 18; i++) ev(5'(i), 32'h0100_0000 * i + 32'h55, 1'b1);
        chk("ovf_set", {31'b0, overflow}, 32'd1);
        wait_idle(18000, "ovf_drain");
        chk("ovf_nbytes", rx_bytes.size(), 32'd102);
        if (rx_bytes.size() >= 102) begin
            chk_frame(0,  5'd1,  32'h0100_0055, "ovf_f0");
            chk_frame(16, 5'd17, 32'h1100_0055, "ovf_f16");
        end
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);
        do_reset();
        @(negedge clk);
        chk("ovf_cleared", {31'b0, overflow}, 32'd0);

        // Full FIFO with a push on the very edge that pops
        for (int i = 1; i <= 17; i++) ev(5'(i), 32'hF000_0000 + i, 1'b1);
        e0 = last_ev - 16;
        chk("full_no_ovf", {31'b0, overflow}, 32'd0);
        wait_cyc(e0 + 961);
        ev(5'd20, 32'hDEAD_BEEF, 1'b1);
        chk("fullpop_edge", last_ev, e0 + 962);
        chk("fullpop_ovf", {31'b0, overflow}, 32'd0);
        wait_idle(19000, "fullpop_drain");
        chk("fullpop_nbytes", rx_bytes.size(), 32'd108);
        if (rx_bytes.size() >= 108) chk_frame(17, 5'd20, 32'hDEAD_BEEF, "fullpop_last");
        chk("fullpop_ovf_end", {31'b0, overflow}, 32'd0);

        // Reset during the start bit of byte 2 with 4 events queued
        rx_bytes.delete(); rx_t0.delete();
        for (int i = 11; i <= 15; i++) ev(5'(i), 32'h0000_0A00 + i, 1'b1);
        e0 = last_ev - 4;
        wait_cyc(e0 + 2 + 2*10*CPB + 4);
        chk("midrst_pre_tx", {31'b0, tx_serial}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tx",   {31'b0, tx_serial}, 32'd1);
        chk("midrst_busy", {31'b0, busy},      32'd0);
        @(negedge clk);
        rst = 1'b0;
        rx_bytes.delete(); rx_t0.delete();
        repeat (2000) @(negedge clk);
        chk("midrst_silent", rx_bytes.size(), 32'd0);
        ev(5'd7, 32'hCAFE_F00D, 1'b1);
        wait_idle(1200, "midrst_new_drain");
        chk("midrst_nbytes", rx_bytes.size(), 32'd6);
        if (rx_bytes.size() >= 6) chk_frame(0, 5'd7, 32'hCAFE_F00D, "midrst_new");

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_trace_uart_tx.md
# reg_trace_uart_tx

Serial trace transmitter: captures register-file writeback events from the pipeline's WB stage and streams them to the host over a UART TX line, the return path for the instruction-load UART receiver. Events are queued in an internal FIFO and sent as fixed 6-byte frames, so the host can reconstruct architectural register state without the VGA debug view. It sits at top level beside the VGA debug block, tapping the same WB signals (reg_write, write-back id, writeback data).

## Interface
Parameters:
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: UART bit rate. CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division), and must be ≥ 2.
- FIFO_DEPTH, 16: number of event entries. Must be a power of 2, ≥ 2.

Ports:
- clk  in  1  system clock; the single clock domain.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  capture enable, driven from the UART collector's start. While 0, events are ignored and the transmitter is unaffected.
- reg_write  in  1  WB-stage register write strobe.
- write_id  in  5  destination register index.
- write_data  in  32  value written.
- tx_serial  out  1  UART line. Idle high, 8N1.
- busy  out  1  FIFO non-empty or a frame in flight.
- overflow  out  1  sticky flag: an event was dropped.

## Operation
- **Capture.** An event is pushed on any cycle where start=1, reg_write=1 and write_id≠0. Each entry is {write_id, write_data}, 37 bits. Writes to x0 are never pushed.
- **Full FIFO.**
  - A push while full and not popping in the same cycle: the event is dropped and overflow is set.
  - Push and pop in the same cycle while full: the push is accepted and overflow is unchanged.
  - overflow clears only on rst.
- **Frame format.** 6 bytes, sent in this order:
  1. 8'hA5 (sync byte).
  2. {3'b000, write_id}.
  3. write_data[7:0].
  4. write_data[15:8].
  5. write_data[23:16].
  6. write_data[31:24].
- **Byte format.** Start bit 0, data bits LSB first, stop bit 1. Each bit is held for exactly CLKS_PER_BIT cycles.
- **Frame FSM states:**
  - IDLE: if the FIFO is non-empty, pop the head entry into the frame register, set byte_idx=0, go to SEND.
  - SEND: issue byte[byte_idx] to the byte serializer. When the serializer reports done, increment byte_idx. After byte 5 is done, go to IDLE.
- **Byte serializer states:** READY → START → DATA (bit counter 0..7) → STOP → READY. The bit-period counter reloads at each bit boundary.
- busy = FIFO non-empty OR frame FSM ≠ IDLE.

## Timing
- Reset values:
  - tx_serial = 1, busy = 0, overflow = 0.
  - FIFO empty (read/write pointers 0), FSM IDLE, serializer READY.
- **Reset mid-frame.** tx_serial is high on the cycle after rst is sampled, and all queued events are discarded.
- **First-bit latency.** An event sampled at edge N is in the FIFO after edge N. The pop occurs at edge N+1. tx_serial falls (start bit) after edge N+2.
- **Within a frame.** Bytes go back-to-back: the next start bit immediately follows a stop bit, with no idle cycles.
- **Between frames.** Exactly one idle-high cycle (the IDLE pop cycle).
- **Frame length.** 60·CLKS_PER_BIT cycles, plus 1 idle cycle between consecutive frames.
- **Counter widths.**
  - Bit-period counter: $clog2(CLKS_PER_BIT) bits.
  - FIFO pointers: $clog2(FIFO_DEPTH)+1 bits. Full/empty are decided by MSB compare.
- **busy and start.** busy may remain 1 after start falls until the FIFO drains.

## Structure
- common_pkg gains:
  - UART_TRACE_SYNC = 8'hA5.
  - TRACE_FRAME_BYTES = 6.
  - typedef trace_entry_t, a packed struct {logic [4:0] id; logic [31:0] data;}.
- One sub-module, uart_tx_byte, implements the byte serializer.
  - Ports: clk, rst, data[7:0], valid, ready, tx_serial.
  - Parameter: CLKS_PER_BIT.
- The FIFO is inline (register array plus pointers). No separate module.

## Test plan
Bench configuration: CLK_FREQ=16, BAUD_RATE=1, giving CLKS_PER_BIT=16.
- **Single event.** Reset, start=1, one event id=5, data=32'h12345678. Expect on tx_serial: A5 05 78 56 34 12, start bit falling 2 cycles after the event, frame 960 cycles long, then busy=0.
- **x0 filter and start gating.** Event id=0 data=32'hFFFFFFFF, then id=3 with start=0. Expect tx_serial constantly 1, busy=0.
- **Burst.** 3 events on consecutive cycles (ids 1,2,3). Expect 3 frames in order, separated by exactly 1 idle-high cycle each.
- **Overflow.** 18 consecutive events with FIFO_DEPTH=16. Expect the 1st popped after its cycle, the next 16 queued, the 18th dropped, overflow=1 and sticky. Exactly 17 frames are sent.
- **Full with simultaneous pop.** Fill the FIFO, then push on the pop cycle. Expect the push accepted and overflow=0.
- **Reset mid-frame.** Assert rst during byte 2 of a frame with 4 events queued. Expect tx_serial=1 the next cycle, busy=0, no further frames sent, and a new event afterwards framed correctly.
